sipo_framer: RTL and testbench

SIPO_FRAMER -- requirements
Module: sipo_framer

---
 rtl/sipo_framer.sv | 86 ++++++++
 tb/tb_sipo_framer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sipo_framer.sv
// Serial-in/parallel-out framer: gathers DATA_W bits on shift_en into a
// registered frame with a one-deep valid/ready output buffer and a sticky overrun flag.
module sipo_framer #(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 1,
  localparam int CW       = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              data_i,
  output logic [DATA_W-1:0] frame_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              overrun_o,
  output logic [CW-1:0]     bit_cnt_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_nxt;
  logic [CW-1:0]     cnt_q;
  logic              done, load, ovr_set;

  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign sr_nxt = {data_i, sr_q[DATA_W-1:1]};
    end else begin : g_msb
      assign sr_nxt = {sr_q[DATA_W-2:0], data_i};
    end
  endgenerate

  assign done = shift_en && (cnt_q == CW'(DATA_W - 1));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      EMPTY: if (done) begin
        state_d = FULL;
        load    = 1'b1;
      end
      FULL: begin
        if (done) begin
          // A completion while full survives only if the held frame is taken now
          if (ready_i) load    = 1'b1;
          else         ovr_set = 1'b1;
        end else if (ready_i) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= EMPTY;
      sr_q      <= '0;
      cnt_q     <= '0;
      frame_o   <= '0;
      overrun_o <= 1'b0;
    end else if (clear) begin
      state_q   <= EMPTY;
      sr_q      <= '0;
      cnt_q     <= '0;
      frame_o   <= '0;
      overrun_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (shift_en) begin
        sr_q  <= sr_nxt;
        cnt_q <= done ? '0 : cnt_q + CW'(1);
      end
      if (load)    frame_o   <= sr_nxt;
      if (ovr_set) overrun_o <= 1'b1;
    end
  end

  assign valid_o   = (state_q == FULL);
  assign bit_cnt_o = cnt_q;

endmodule

// File: tb/tb_sipo_framer.sv
// Directed bench for sipo_framer: LSB-first and MSB-first 8-bit framers and a 12-bit LSB-first framer.
module tb_sipo_framer;

  logic clk = 1'b0;
  logic nrst, clear, data_i, ready_i;
  logic [2:0] en;

  logic [7:0]  fr_a, fr_b;
  logic [11:0] fr_c;
  logic        vl_a, vl_b, vl_c, ov_a, ov_b, ov_c;
  logic [3:0]  cn_a, cn_b, cn_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_framer #(.DATA_W(8), .LSB_FIRST(1)) u_a (
    .clk(clk), .nrst(nrst), .clear(clear), .shift_en(en[0]), .data_i(data_i),
    .frame_o(fr_a), .valid_o(vl_a), .ready_i(ready_i), .overrun_o(ov_a), .bit_cnt_o(cn_a));
  sipo_framer #(.DATA_W(8), .LSB_FIRST(0)) u_b (
    .clk(clk), .nrst(nrst), .clear(clear), .shift_en(en[1]), .data_i(data_i),
    .frame_o(fr_b), .valid_o(vl_b), .ready_i(ready_i), .overrun_o(ov_b), .bit_cnt_o(cn_b));
  sipo_framer #(.DATA_W(12), .LSB_FIRST(1)) u_c (
    .clk(clk), .nrst(nrst), .clear(clear), .shift_en(en[2]), .data_i(data_i),
    .frame_o(fr_c), .valid_o(vl_c), .ready_i(ready_i), .overrun_o(ov_c), .bit_cnt_o(cn_c));

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic shift(input int k, input logic b);
    en = '0; en[k] = 1'b1; data_i = b;
    step();
    en = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if ({fr_a, vl_a, ov_a, cn_a} !== 14'd0) begin errors++;
      $display("FAIL reset_a: got %h/%b/%b/%0d want 0", fr_a, vl_a, ov_a, cn_a); end
    checks++; if ({fr_c, vl_c, ov_c, cn_c} !== 18'd0) begin errors++;
      $display("FAIL reset_c: got %h/%b/%b/%0d want 0", fr_c, vl_c, ov_c, cn_c); end
    nrst = 1'b1;
    step();
    ready_i = 1'b1; data_i = 1'b1; step(); ready_i = 1'b0;
    checks++; if ({vl_a, cn_a, fr_a} !== 13'd0) begin errors++;
      $display("FAIL idle_after_reset: got v=%b cnt=%0d fr=%h want 0", vl_a, cn_a, fr_a); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] bits;
    bits = 8'b0101_0011;  // sent bit0 first: 1,1,0,0,1,0,1,0
    for (int i = 0; i < 7; i++) shift(0, bits[i]);
    checks++; if (cn_a !== 4'd7 || vl_a !== 1'b0) begin errors++;
      $display("FAIL lsb_partial: got cnt=%0d v=%b want 7/0", cn_a, vl_a); end
    shift(0, bits[7]);
    checks++; if (fr_a !== 8'h53 || vl_a !== 1'b1 || cn_a !== 4'd0) begin errors++;
      $display("FAIL lsb_frame: got %h v=%b cnt=%0d want 53/1/0", fr_a, vl_a, cn_a); end
  endtask

  task automatic test_msb_first_gaps();
    logic [7:0] bits;
    bits = 8'b0101_0011;  // sent bit7 first: 0,1,0,1,0,0,1,1
    for (int i = 0; i < 8; i++) begin
      shift(1, bits[7-i]);
      for (int g = 0; g < (i % 4); g++) begin
        data_i = ~data_i; step();
      end
      if (i == 5) begin
        checks++; if (cn_b !== 4'd6) begin errors++;
          $display("FAIL gap_hold_cnt: got %0d want 6", cn_b); end
      end
    end
    checks++; if (fr_b !== 8'h53 || vl_b !== 1'b1 || cn_b !== 4'd0) begin errors++;
      $display("FAIL msb_frame: got %h v=%b cnt=%0d want 53/1/0", fr_b, vl_b, cn_b); end
  endtask

  task automatic test_overrun();
    do_clear();
    for (int i = 0; i < 8; i++) shift(0, i inside {0, 1, 4, 6});  // 0x53
    for (int i = 0; i < 8; i++) shift(0, 1'b1);                    // 0xFF dropped
    checks++; if (fr_a !== 8'h53 || ov_a !== 1'b1 || vl_a !== 1'b1) begin errors++;
      $display("FAIL overrun_hold: got %h ov=%b v=%b want 53/1/1", fr_a, ov_a, vl_a); end
    ready_i = 1'b1; step(); ready_i = 1'b0;
    checks++; if (vl_a !== 1'b0 || ov_a !== 1'b1) begin errors++;
      $display("FAIL overrun_sticky: got v=%b ov=%b want 0/1", vl_a, ov_a); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    do_clear();
    for (int i = 0; i < 8; i++) shift(0, i inside {0, 1, 4, 6});  // 0x53
    w = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      ready_i = (i == 7);
      shift(0, w[i]);
    end
    ready_i = 1'b0;
    checks++; if (fr_a !== 8'h0F || vl_a !== 1'b1 || ov_a !== 1'b0) begin errors++;
      $display("FAIL b2b: got %h v=%b ov=%b want 0f/1/0", fr_a, vl_a, ov_a); end
    step();
    checks++; if (fr_a !== 8'h0F || vl_a !== 1'b1) begin errors++;
      $display("FAIL stable_no_ready: got %h v=%b want 0f/1", fr_a, vl_a); end
    ready_i = 1'b1; step(); step(); ready_i = 1'b0;
    checks++; if (vl_a !== 1'b0 || fr_a !== 8'h0F) begin errors++;
      $display("FAIL ready_empty: got v=%b fr=%h want 0/0f", vl_a, fr_a); end
  endtask

  task automatic test_async_reset();
    logic [7:0] w;
    for (int i = 0; i < 4; i++) shift(0, 1'b1);
    checks++; if (cn_a !== 4'd4) begin errors++;
      $display("FAIL pre_reset_cnt: got %0d want 4", cn_a); end
    #2 nrst = 1'b0; #1;
    checks++; if ({fr_a, vl_a, ov_a, cn_a} !== 14'd0) begin errors++;
      $display("FAIL async_reset: got %h/%b/%b/%0d want 0", fr_a, vl_a, ov_a, cn_a); end
    #1 nrst = 1'b1;
    step();
    w = 8'hA5;
    for (int i = 0; i < 8; i++) shift(0, w[i]);
    checks++; if (fr_a !== 8'hA5 || vl_a !== 1'b1 || cn_a !== 4'd0) begin errors++;
      $display("FAIL post_reset_frame: got %h v=%b cnt=%0d want a5/1/0", fr_a, vl_a, cn_a); end
  endtask

  task automatic test_clear_priority();
    for (int i = 0; i < 8; i++) shift(0, 1'b1);  // dropped, sets overrun
    checks++; if (ov_a !== 1'b1) begin errors++;
      $display("FAIL ov_before_clear: got %b want 1", ov_a); end
    for (int i = 0; i < 7; i++) shift(0, 1'b1);
    clear = 1'b1; ready_i = 1'b1;
    shift(0, 1'b1);
    clear = 1'b0; ready_i = 1'b0;
    checks++; if ({fr_a, vl_a, ov_a, cn_a} !== 14'd0) begin errors++;
      $display("FAIL clear_prio: got %h/%b/%b/%0d want 0", fr_a, vl_a, ov_a, cn_a); end
  endtask

  task automatic test_width12();
    logic [11:0] w;
    do_clear();
    w = 12'hA53;
    for (int i = 0; i < 11; i++) shift(2, w[i]);
    checks++; if (cn_c !== 4'd11 || vl_c !== 1'b0) begin errors++;
      $display("FAIL w12_partial: got cnt=%0d v=%b want 11/0", cn_c, vl_c); end
    shift(2, w[11]);
    checks++; if (fr_c !== 12'hA53 || vl_c !== 1'b1 || cn_c !== 4'd0) begin errors++;
      $display("FAIL w12_frame: got %h v=%b cnt=%0d want a53/1/0", fr_c, vl_c, cn_c); end
  endtask

  initial begin
    nrst = 1'b0; clear = 1'b0; data_i = 1'b0; ready_i = 1'b0; en = '0;
    test_reset();
    test_lsb_first();
    test_msb_first_gaps();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    test_clear_priority();
    test_width12();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
